// File: rtl/cereal_pkg.sv
// Shared definitions for the cereal serial family: frame state encodings,
// parity modes and the parity helper used by transmitter and receiver.
package cereal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Caller zero-extends the word, so the unused upper bits do not disturb the XOR.
    function automatic logic calc_parity(input logic [8:0] word, input int mode);
        logic ones_odd;
        ones_odd = ^word;
        return (mode == PAR_ODD) ? ~ones_odd : ones_odd;
    endfunction

endpackage

// File: rtl/cereal_if.sv
// Word handshake plus serial line outputs between system logic and the transmitter.
interface cereal_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 cereal;
    logic                 busy;

    modport master (output data, output valid, input ready, input cereal, input busy);
    modport slave  (input data, input valid, output ready, output cereal, output busy);
endinterface

// File: rtl/cereal_baud.sv
// Bit-period tick generator: counts 0..DIV-1 while running and ticks on the
// last cycle of each bit; held at zero when idle or restarted.
module cereal_baud #(
    parameter int DIV   = 5208,
    parameter int DIV_W = 16
) (
    input  logic sysclk,
    input  logic reset,
    input  logic restart,
    input  logic run,
    output logic tick
);

    if (DIV < 2 || DIV_W < 1 || DIV_W > 62 || (64'(1) << DIV_W) <= 64'(DIV)) begin : g_bad_div
        $fatal(1, "cereal_baud: DIV must be >= 2 and fit in DIV_W bits");
    end

    logic [DIV_W-1:0] cnt_reg;
    logic             last;

    assign last = (cnt_reg == DIV_W'(DIV - 1));
    assign tick = run & last;

    always_ff @(posedge sysclk) begin
        if (reset || restart || !run) begin
            cnt_reg <= '0;
        end else if (last) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/cereal_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and sends
// start, LSB-first data, optional parity and stop bits on an idle-high line.
module cereal_tx
    import cereal_pkg::*;
#(
    parameter int DIV       = 5208,
    parameter int DIV_W     = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic     sysclk,
    input  logic     reset,
    cereal_if.slave  bus
);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || DIV < 2) begin : g_bad_params
        $fatal(1, "cereal_tx: illegal frame parameters");
    end

    state_t               state_reg, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 par_reg, par_next;
    logic [3:0]           bit_cnt_reg, bit_cnt_next;
    logic                 stop_cnt_reg, stop_cnt_next;
    logic                 cereal_reg, cereal_next;
    logic                 busy_reg, busy_next;
    logic                 tick;
    logic                 accept;

    assign bus.ready  = (state_reg == ST_IDLE) & ~reset;
    assign bus.cereal = cereal_reg;
    assign bus.busy   = busy_reg;
    assign accept     = bus.valid & bus.ready;

    cereal_baud #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_baud (
        .sysclk  (sysclk),
        .reset   (reset),
        .restart (accept),
        .run     (state_reg != ST_IDLE),
        .tick    (tick)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            par_reg      <= 1'b0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            cereal_reg   <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            par_reg      <= par_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            cereal_reg   <= cereal_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept) state_next = ST_START;
            ST_START:  if (tick) state_next = ST_DATA;
            ST_DATA: begin
                if (tick && bit_cnt_reg == 4'(DATA_BITS - 1)) begin
                    state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (tick) state_next = ST_STOP;
            ST_STOP: begin
                if (tick && stop_cnt_reg == 1'(STOP_BITS - 1)) state_next = ST_IDLE;
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    // Line level is computed from the upcoming state so the pin changes on the
    // same edge as the state and stays a clean register output.
    always_comb begin
        shift_next    = shift_reg;
        par_next      = par_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    shift_next    = bus.data;
                    par_next      = calc_parity(9'(bus.data), PARITY);
                    bit_cnt_next  = '0;
                    stop_cnt_next = 1'b0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                end
            end
            ST_STOP: begin
                if (tick) stop_cnt_next = stop_cnt_reg + 1'b1;
            end
            default: ;
        endcase

        case (state_next)
            ST_START:  cereal_next = 1'b0;
            ST_DATA:   cereal_next = shift_next[0];
            ST_PARITY: cereal_next = par_reg;
            default:   cereal_next = 1'b1;
        endcase
        busy_next = (state_next != ST_IDLE);
    end

endmodule

// File: tb/tb_cereal_tx.sv
// Directed and random frames on five transmitter configurations, each compared
// cycle by cycle against a bit-list model of the expected serial frame.
module tb_cereal_tx;
    import cereal_pkg::*;

    localparam int DIV  = 4;
    localparam int NDUT = 5;
    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2, 4: 7N1
    localparam int DB [NDUT] = '{8, 8, 8, 8, 7};
    localparam int PM [NDUT] = '{PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE, PAR_NONE};
    localparam int SB [NDUT] = '{1, 1, 1, 2, 1};

    typedef bit bitq_t[$];

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       valid_a  [NDUT];
    logic [8:0] data_a   [NDUT];
    logic       ready_w  [NDUT];
    logic       cereal_w [NDUT];
    logic       busy_w   [NDUT];
    int         nerr = 0;
    int         nchk = 0;

    always #5 sysclk = ~sysclk;

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            cereal_if #(.DATA_BITS(DB[gi])) bus ();
            assign bus.data     = data_a[gi][DB[gi]-1:0];
            assign bus.valid    = valid_a[gi];
            assign ready_w[gi]  = bus.ready;
            assign cereal_w[gi] = bus.cereal;
            assign busy_w[gi]   = bus.busy;

            cereal_tx #(
                .DIV       (DIV),
                .DIV_W     (4),
                .DATA_BITS (DB[gi]),
                .PARITY    (PM[gi]),
                .STOP_BITS (SB[gi])
            ) dut (
                .sysclk (sysclk),
                .reset  (reset),
                .bus    (bus.slave)
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected line level, one entry per bit, straight from the frame definition.
    function automatic bitq_t frame_bits(input int i, input logic [8:0] w);
        bitq_t q;
        int    ones = 0;
        q.push_back(1'b0);
        for (int k = 0; k < DB[i]; k++) begin
            q.push_back(w[k]);
            ones += int'(w[k]);
        end
        if (PM[i] == PAR_ODD)  q.push_back((ones % 2) == 0);
        if (PM[i] == PAR_EVEN) q.push_back((ones % 2) == 1);
        for (int s = 0; s < SB[i]; s++) q.push_back(1'b1);
        return q;
    endfunction

    // Entered in the first cycle after the accepting edge; returns in the cycle after the frame.
    task automatic check_frame(input int i, input logic [8:0] w);
        bitq_t q;
        q = frame_bits(i, w);
        for (int c = 0; c < q.size() * DIV; c++) begin
            chk($sformatf("dut%0d cereal c%0d", i, c), cereal_w[i], q[c / DIV]);
            chk($sformatf("dut%0d busy c%0d", i, c), busy_w[i], 1'b1);
            chk($sformatf("dut%0d ready c%0d", i, c), ready_w[i], 1'b0);
            @(negedge sysclk);
        end
        chk($sformatf("dut%0d idle cereal", i), cereal_w[i], 1'b1);
        chk($sformatf("dut%0d idle busy", i), busy_w[i], 1'b0);
        chk($sformatf("dut%0d idle ready", i), ready_w[i], 1'b1);
        $display("tx dut%0d word=%03h frame_bits=%0d", i, w, q.size());
    endtask

    task automatic send(input int i, input logic [8:0] w);
        data_a[i]  = w;
        valid_a[i] = 1'b1;
        chk($sformatf("dut%0d ready before accept", i), ready_w[i], 1'b1);
        @(negedge sysclk);
        valid_a[i] = 1'b0;
        data_a[i]  = 9'($urandom);
        check_frame(i, w);
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            valid_a[i] = 1'b1;
            data_a[i]  = 9'h000;
        end

        // Reset held for three cycles with valid asserted.
        repeat (3) begin
            @(negedge sysclk);
            for (int i = 0; i < NDUT; i++) begin
                chk($sformatf("dut%0d reset cereal", i), cereal_w[i], 1'b1);
                chk($sformatf("dut%0d reset busy", i), busy_w[i], 1'b0);
                chk($sformatf("dut%0d reset ready", i), ready_w[i], 1'b0);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < NDUT; i++) valid_a[i] = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) chk($sformatf("dut%0d ready after reset", i), ready_w[i], 1'b1);
        @(negedge sysclk);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("dut%0d no frame cereal", i), cereal_w[i], 1'b1);
            chk($sformatf("dut%0d no frame busy", i), busy_w[i], 1'b0);
        end

        send(0, 9'h0A5);
        send(1, 9'h007);
        send(2, 9'h007);

        // Back-to-back 8N2 with valid held across both frames.
        data_a[3]  = 9'h000;
        valid_a[3] = 1'b1;
        chk("dut3 ready before b2b", ready_w[3], 1'b1);
        @(negedge sysclk);
        data_a[3] = 9'h0FF;
        check_frame(3, 9'h000);
        @(negedge sysclk);
        valid_a[3] = 1'b0;
        check_frame(3, 9'h0FF);

        // Reset during data bit 3 (frame cycles 16..19), bit value 0.
        data_a[0]  = 9'h052;
        valid_a[0] = 1'b1;
        @(negedge sysclk);
        valid_a[0] = 1'b0;
        repeat (17) @(negedge sysclk);
        chk("dut0 bit3 before abort", cereal_w[0], 1'b0);
        reset = 1'b1;
        @(negedge sysclk);
        chk("dut0 abort cereal", cereal_w[0], 1'b1);
        chk("dut0 abort busy", busy_w[0], 1'b0);
        chk("dut0 abort ready", ready_w[0], 1'b0);
        reset = 1'b0;
        #1;
        chk("dut0 ready after abort", ready_w[0], 1'b1);
        @(negedge sysclk);
        chk("dut0 stays idle", cereal_w[0], 1'b1);
        send(0, 9'h03C);

        // 7N1 with bit 7 set in the word; data scrambled after accept.
        send(4, 9'h0D5);

        for (int i = 0; i < NDUT; i++) begin
            repeat (3) send(i, 9'($urandom_range(0, 511)));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
